// File: rtl/quad_step_axis_ctrl.sv
// Quadrature step generator plus an x4 quadrature decoder.
// The generator emits a programmable number of A/B steps at a programmable
// rate. It supports single-shot, continuous and auto-reverse modes.
// The decoder turns an external (asynchronous) A/B pair into a signed
// position and counts illegal transitions.
// Optional build macro: FILTER_EN adds a per-input stability filter of
// FILT_DEPTH samples between the synchroniser and the decoder.
//
// state   | meaning
// ST_IDLE | waiting for start; outputs hold
// ST_RUN  | prescaler running, emitting one step per terminal count
module quad_step_axis_ctrl #(
  parameter int CNT_W      = 32,
  parameter int LIMIT_W    = 16,
  parameter int DIV_W      = 16,
  parameter int FILT_DEPTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               start,
  input  logic               dir_in,
  input  logic [1:0]         mode,
  input  logic [LIMIT_W-1:0] limit,
  input  logic [DIV_W-1:0]   step_div,
  output logic               A_out,
  output logic               B_out,
  output logic               motor_dir,
  output logic [CNT_W-1:0]   step_count,
  output logic               busy,
  output logic               done,
  input  logic               enc_a_in,
  input  logic               enc_b_in,
  output logic [CNT_W-1:0]   position,
  output logic               direction,
  output logic [7:0]         err_cnt
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (FILT_DEPTH < 1 || CNT_W < LIMIT_W) begin : g_param_check
    $error("quad_step_axis_ctrl: FILT_DEPTH must be >= 1 and CNT_W >= LIMIT_W");
  end

  // Next AB pattern; CW walks 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] ab_next(input logic [1:0] ab, input logic ccw);
    logic [1:0] nxt;
    case (ab)
      2'b00:   nxt = ccw ? 2'b01 : 2'b10;
      2'b10:   nxt = ccw ? 2'b00 : 2'b11;
      2'b11:   nxt = ccw ? 2'b10 : 2'b01;
      default: nxt = ccw ? 2'b11 : 2'b00;
    endcase
    return nxt;
  endfunction

  // Position of an AB pattern within the CW cycle.
  function automatic logic [1:0] ab_index(input logic [1:0] ab);
    logic [1:0] idx;
    case (ab)
      2'b00:   idx = 2'd0;
      2'b10:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // ---------------- generator ----------------
  state_t             state_q, state_d;
  logic [DIV_W-1:0]   pre_q, pre_d;
  logic [1:0]         ab_q, ab_d;
  logic               mdir_q, mdir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LIMIT_W-1:0] lim_q, lim_d;
  logic               done_q, done_d;
  logic [DIV_W-1:0]   div_eff;
  logic [CNT_W-1:0]   cnt_next;

  assign div_eff = (step_div == '0) ? DIV_W'(1) : step_div;

  // Generator next-state: start/stop, prescaler, step emission and segment restarts.
  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    ab_d     = ab_q;
    mdir_d   = mdir_q;
    cnt_d    = cnt_q;
    lim_d    = lim_q;
    done_d   = 1'b0;
    cnt_next = cnt_q + CNT_ONE;
    case (state_q)
      ST_IDLE: begin
        if (enable && start) begin
          if (limit == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            mdir_d  = dir_in;
            lim_d   = limit;
            cnt_d   = '0;
            pre_d   = '0;
          end
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (pre_q >= div_eff) begin
          // >= so that lowering step_div mid-run cannot strand the prescaler
          pre_d = '0;
          ab_d  = ab_next(ab_q, mdir_q);
          cnt_d = cnt_next;
          if (cnt_next == CNT_W'(lim_q)) begin
            done_d = 1'b1;
            case (mode)
              2'd1: begin
                cnt_d = '0;
                lim_d = limit;
                if (limit == '0) state_d = ST_IDLE;
              end
              2'd2: begin
                cnt_d  = '0;
                lim_d  = limit;
                mdir_d = ~mdir_q;
                if (limit == '0) state_d = ST_IDLE;
              end
              default: state_d = ST_IDLE;
            endcase
          end
        end else begin
          pre_d = pre_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Generator state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      ab_q    <= 2'b00;
      mdir_q  <= 1'b0;
      cnt_q   <= '0;
      lim_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      ab_q    <= ab_d;
      mdir_q  <= mdir_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      done_q  <= done_d;
    end
  end

  assign A_out      = ab_q[1];
  assign B_out      = ab_q[0];
  assign motor_dir  = mdir_q;
  assign step_count = cnt_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = done_q;

  // ---------------- decoder ----------------
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] dec_in;

  // Two-flop synchroniser on the asynchronous encoder pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {enc_a_in, enc_b_in};
      sync2_q <= sync1_q;
    end
  end

`ifdef FILTER_EN
  localparam int FCW = (FILT_DEPTH > 1) ? $clog2(FILT_DEPTH) : 1;
  logic [1:0]     filt_q;
  logic [FCW-1:0] fcnt_q [2];

  // Each bit only moves once the new level has been seen FILT_DEPTH cycles in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 2'b00;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FCW'(FILT_DEPTH - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign dec_in = filt_q;
`else
  assign dec_in = sync2_q;
`endif

  logic [1:0]       prev_q;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             ddir_q, ddir_d;
  logic [7:0]       err_q, err_d;
  logic [1:0]       step_diff;

  // Classify the AB change since last cycle: forward, reverse or illegal double change.
  always_comb begin
    pos_d     = pos_q;
    ddir_d    = ddir_q;
    err_d     = err_q;
    step_diff = ab_index(dec_in) - ab_index(prev_q);
    case (step_diff)
      2'd1: begin
        pos_d  = pos_q + CNT_ONE;
        ddir_d = 1'b0;
      end
      2'd3: begin
        pos_d  = pos_q - CNT_ONE;
        ddir_d = 1'b1;
      end
      2'd2: begin
        if (err_q != 8'hFF) err_d = err_q + 8'd1;
      end
      default: ;
    endcase
  end

  // Decoder state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 2'b00;
      pos_q  <= '0;
      ddir_q <= 1'b0;
      err_q  <= '0;
    end else begin
      prev_q <= dec_in;
      pos_q  <= pos_d;
      ddir_q <= ddir_d;
      err_q  <= err_d;
    end
  end

  assign position  = pos_q;
  assign direction = ddir_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_quad_step_axis_ctrl.sv
// Directed bench for quad_step_axis_ctrl: table-driven decoder vectors plus
// generator runs checked cycle by cycle against a small step model.
module tb_quad_step_axis_ctrl;

`ifdef FILTER_EN
  localparam int DEC_LAT = 6;
`else
  localparam int DEC_LAT = 3;
`endif
  localparam int NO_DROP = 1 << 30;

  logic        clk = 1'b0;
  logic        rst, enable, start, dir_in;
  logic [1:0]  mode;
  logic [15:0] limit, step_div;
  logic        A_out, B_out, motor_dir, busy, done, direction;
  logic [31:0] step_count, position;
  logic [7:0]  err_cnt;
  logic        enc_a_in, enc_b_in;
  logic        loop, ext_a, ext_b;

  assign enc_a_in = loop ? A_out : ext_a;
  assign enc_b_in = loop ? B_out : ext_b;

  quad_step_axis_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .dir_in(dir_in),
    .mode(mode), .limit(limit), .step_div(step_div),
    .A_out(A_out), .B_out(B_out), .motor_dir(motor_dir),
    .step_count(step_count), .busy(busy), .done(done),
    .enc_a_in(enc_a_in), .enc_b_in(enc_b_in),
    .position(position), .direction(direction), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // generator model state carried between runs
  int          g_idx;
  logic        g_mdir;
  logic [31:0] g_cnt;
  logic [31:0] exp_pos;
  logic        exp_dir;

  typedef struct {
    logic        a;
    logic        b;
    logic [31:0] pos;
    logic        dir;
    logic [7:0]  err;
  } dvec_t;
  dvec_t tbl [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] gray(input int idx);
    case (idx & 3)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // Start a run and check every cycle against the model; enable drops before edge drop_at.
  task automatic run_gen(input logic d, input logic [1:0] md, input logic [15:0] lim,
                         input logic [15:0] dv, input int ncyc, input int drop_at);
    int          period;
    logic        run, edone;
    logic [31:0] ph [0:255];
    logic        dh [0:255];
    logic [31:0] pos0, epos;
    logic        dir0, edir;
    period = (dv == 0) ? 2 : int'(dv) + 1;
    pos0 = exp_pos; epos = exp_pos;
    dir0 = exp_dir; edir = exp_dir;
    dir_in = d; mode = md; limit = lim; step_div = dv; enable = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    run   = (lim != 0);
    edone = (lim == 0);
    if (run) begin
      g_cnt  = 0;
      g_mdir = d;
    end
    ph[0] = epos; dh[0] = edir;
    for (int k = 0; k <= ncyc; k++) begin
      if (k > 0) begin
        if (k == drop_at) enable = 1'b0;
        step();
        edone = 1'b0;
        if (run && k >= drop_at) begin
          run = 1'b0;
        end else if (run && (k % period) == 0) begin
          g_idx = g_mdir ? g_idx + 3 : g_idx + 1;
          epos  = g_mdir ? epos - 1 : epos + 1;
          edir  = g_mdir;
          g_cnt = g_cnt + 1;
          if (g_cnt == 32'(lim)) begin
            edone = 1'b1;
            if (md == 2'd1) begin
              g_cnt = 0;
            end else if (md == 2'd2) begin
              g_cnt  = 0;
              g_mdir = ~g_mdir;
            end else begin
              run = 1'b0;
            end
          end
        end
        ph[k] = epos; dh[k] = edir;
      end
      chk("gen_ab", {A_out, B_out}, gray(g_idx));
      chk("gen_busy", busy, run);
      chk("gen_done", done, edone);
      chk("gen_step_count", step_count, g_cnt);
      chk("gen_motor_dir", motor_dir, g_mdir);
      chk("gen_position", position, (k >= DEC_LAT) ? ph[k-DEC_LAT] : pos0);
      chk("gen_direction", direction, (k >= DEC_LAT) ? dh[k-DEC_LAT] : dir0);
    end
    enable  = 1'b1;
    exp_pos = epos;
    exp_dir = edir;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 32'd0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 32'd1, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 1'b1, 32'd2, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b1, 32'd3, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 1'b1, 32'd2, 1'b1, 8'd0};
    tbl[5]  = '{1'b1, 1'b0, 32'd1, 1'b1, 8'd0};
    tbl[6]  = '{1'b0, 1'b1, 32'd1, 1'b1, 8'd1};
    tbl[7]  = '{1'b0, 1'b0, 32'd2, 1'b0, 8'd1};
    tbl[8]  = '{1'b1, 1'b1, 32'd2, 1'b0, 8'd2};
    tbl[9]  = '{1'b0, 1'b1, 32'd3, 1'b0, 8'd2};
    tbl[10] = '{1'b1, 1'b0, 32'd3, 1'b0, 8'd3};
    tbl[11] = '{1'b0, 1'b0, 32'd2, 1'b1, 8'd3};

    loop = 1'b0; ext_a = 1'b0; ext_b = 1'b0;
    rst = 1'b1; enable = 1'b0; start = 1'b0; dir_in = 1'b0;
    mode = 2'd0; limit = 16'd0; step_div = 16'd0;
    step(); step();
    chk("rst_ab", {A_out, B_out}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_step_count", step_count, 32'd0);
    chk("rst_motor_dir", motor_dir, 1'b0);
    chk("rst_position", position, 32'd0);
    chk("rst_direction", direction, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'd0);
    rst = 1'b0;
    step();

    // one CCW edge from zero wraps, with exact latency
    ext_b = 1'b1;
    for (int n = 1; n <= DEC_LAT; n++) begin
      step();
      if (n == DEC_LAT - 1) chk("wrap_before_latency", position, 32'd0);
    end
    chk("wrap_position", position, 32'hFFFF_FFFF);
    chk("wrap_direction", direction, 1'b1);

    for (int i = 0; i < 12; i++) begin
      ext_a = tbl[i].a;
      ext_b = tbl[i].b;
      repeat (DEC_LAT + 1) step();
      chk("dec_position", position, tbl[i].pos);
      chk("dec_direction", direction, tbl[i].dir);
      chk("dec_err_cnt", err_cnt, tbl[i].err);
    end

    // 300 double-bit jumps: error counter saturates, position untouched
    for (int i = 0; i < 300; i++) begin
      ext_a = (i % 2 == 0);
      ext_b = (i % 2 == 0);
      repeat (DEC_LAT + 1) step();
      if (i == 0) chk("illegal_first_err", err_cnt, 8'd4);
    end
    chk("illegal_sat_err", err_cnt, 8'd255);
    chk("illegal_position", position, 32'd2);

`ifdef FILTER_EN
    ext_a = 1'b1;
    step(); step();
    ext_a = 1'b0;
    repeat (12) step();
    chk("glitch_position", position, 32'd2);
    chk("glitch_err_cnt", err_cnt, 8'd255);
`endif

    rst = 1'b1;
    step();
    rst = 1'b0;
    loop = 1'b1;
    g_idx = 0; g_mdir = 1'b0; g_cnt = 0; exp_pos = 0; exp_dir = 1'b0;
    step();

    // start ignored while disabled
    enable = 1'b0; start = 1'b1; limit = 16'd4; step_div = 16'd1;
    step();
    start = 1'b0;
    chk("disabled_start_busy", busy, 1'b0);
    step();
    chk("disabled_start_busy2", busy, 1'b0);
    chk("disabled_start_ab", {A_out, B_out}, 2'b00);

    run_gen(1'b0, 2'd0, 16'd8, 16'd4, 40 + DEC_LAT + 2, NO_DROP);
    chk("single_cw_position", position, 32'd8);
    chk("single_cw_step_count", step_count, 32'd8);

    run_gen(1'b1, 2'd0, 16'd8, 16'd4, 40 + DEC_LAT + 2, NO_DROP);
    chk("single_ccw_position", position, 32'd0);
    chk("single_ccw_direction", direction, 1'b1);
    chk("single_ccw_err_cnt", err_cnt, 8'd0);

    run_gen(1'b0, 2'd2, 16'd3, 16'd1, 30, 25);
    run_gen(1'b1, 2'd1, 16'd2, 16'd0, 24, 15);

    run_gen(1'b0, 2'd0, 16'd8, 16'd4, 40, 27);
    chk("drop_step_count", step_count, 32'd5);
    chk("drop_busy", busy, 1'b0);

    run_gen(1'b0, 2'd0, 16'd2, 16'd2, 12, NO_DROP);
    run_gen(1'b0, 2'd0, 16'd0, 16'd4, 3, NO_DROP);
    chk("lim0_count_held", step_count, 32'd2);

    // reset in the middle of a run
    dir_in = 1'b0; mode = 2'd0; limit = 16'd8; step_div = 16'd1; enable = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    step();
    chk("midrst_ab", {A_out, B_out}, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_step_count", step_count, 32'd0);
    chk("midrst_motor_dir", motor_dir, 1'b0);
    chk("midrst_position", position, 32'd0);
    chk("midrst_direction", direction, 1'b0);
    chk("midrst_err_cnt", err_cnt, 8'd0);
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
